// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length,
// and streams frame bytes with sof/eof markers plus good/bad counters.
module gmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        rgmii_rxc,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  frm_data,
  output logic        frm_valid,
  output logic        frm_sof,
  output logic        frm_eof,
  output logic        frm_err,
  output logic [10:0] frm_len,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RES  = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT  = 11'h7FF;

  logic [1:0]  state_q, state_d;
  logic [2:0]  pre_q, pre_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_v_q, hold_v_d;
  logic        first_q, first_d;
  logic        er_q, er_d;
  logic [10:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic [10:0] flen_q, flen_d;
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;

  logic good_inc, bad_inc, frm_bad;

  // Bit-serial CRC in MSB-first register form, data fed LSB first
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign frm_bad = (crc_q != CRC_RES) || (len_q < MIN_L) ||
                   (len_q > MAX_L) || er_q;

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    first_d  = first_q;
    er_d     = er_q;
    len_d    = len_q;
    crc_d    = crc_q;
    data_d   = 8'h00;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    flen_d   = 11'd0;
    good_inc = 1'b0;
    bad_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55) begin
            state_d = S_PRE;
            pre_d   = 3'd1;
          end else begin
            state_d = S_DROP;
            bad_inc = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
          bad_inc = 1'b1;
        end else if (!gmii_rx_er && gmii_rxd == 8'hD5) begin
          state_d  = S_DATA;
          hold_v_d = 1'b0;
          first_d  = 1'b1;
          er_d     = 1'b0;
          len_d    = 11'd0;
          crc_d    = CRC_INIT;
        end else if (!gmii_rx_er && gmii_rxd == 8'h55 &&
                     pre_q != 3'd7) begin
          pre_d = pre_q + 3'd1;
        end else begin
          state_d = S_DROP;
          bad_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (gmii_rx_dv) begin
          hold_d   = gmii_rxd;
          hold_v_d = 1'b1;
          crc_d    = crc_byte(crc_q, gmii_rxd);
          if (len_q != LEN_SAT) len_d = len_q + 11'd1;
          if (gmii_rx_er) er_d = 1'b1;
          if (hold_v_q) begin
            valid_d = 1'b1;
            data_d  = hold_q;
            sof_d   = first_q;
            first_d = 1'b0;
          end
        end else begin
          state_d  = S_IDLE;
          hold_v_d = 1'b0;
          if (hold_v_q) begin
            valid_d  = 1'b1;
            data_d   = hold_q;
            sof_d    = first_q;
            eof_d    = 1'b1;
            err_d    = frm_bad;
            flen_d   = len_q;
            good_inc = !frm_bad;
            bad_inc  = frm_bad;
          end else begin
            bad_inc = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!gmii_rx_dv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    good_d = good_q + {15'd0, good_inc};
    bad_d  = bad_q + {15'd0, bad_inc};
  end

  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pre_q    <= 3'd0;
      hold_q   <= 8'h00;
      hold_v_q <= 1'b0;
      first_q  <= 1'b0;
      er_q     <= 1'b0;
      len_q    <= 11'd0;
      crc_q    <= CRC_INIT;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
      flen_q   <= 11'd0;
      good_q   <= 16'd0;
      bad_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      first_q  <= first_d;
      er_q     <= er_d;
      len_q    <= len_d;
      crc_q    <= crc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
      flen_q   <= flen_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
    end
  end

  assign frm_data  = data_q;
  assign frm_valid = valid_q;
  assign frm_sof   = sof_q;
  assign frm_eof   = eof_q;
  assign frm_err   = err_q;
  assign frm_len   = flen_q;
  assign cnt_good  = good_q;
  assign cnt_bad   = bad_q;

endmodule
